// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - Sobel sequencer types and window constants (SOBEL_SEQ_SKIP_WRAP_EN)
package sobel_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    RELEASE = 3'd3,
    ERROR   = 3'd4
  } seq_state_t;

  localparam int NUM_WINDOWS = 8;
  localparam int OPT_W       = 3;

`ifdef SOBEL_SEQ_SKIP_WRAP_EN
  // Windows 6 and 7 straddle the buffer wrap and are skipped.
  localparam int NWIN = 6;
`else
  localparam int NWIN = NUM_WINDOWS;
`endif

  localparam logic [OPT_W-1:0] LAST_WIN = OPT_W'(NWIN - 1);

endpackage

// File: rtl/sobel_window_sequencer_if.sv
// rtl/sobel_window_sequencer_if.sv - handshake bundle between line buffer, sequencer and window controller
interface sobel_window_sequencer_if #(
  parameter int LINE_W = 8
);
  import sobel_pkg::*;

  logic              seq_en;
  logic              abort;
  logic              buf_valid;
  logic              stall;
  logic              sobel_ready;
  logic [OPT_W-1:0]  option;
  logic              computeSobel;
  logic              buf_release;
  logic              frame_done;
  logic [LINE_W-1:0] line_count;
  logic              busy;
  logic              timeout_err;

  modport master (
    input  seq_en, abort, buf_valid, stall, sobel_ready,
    output option, computeSobel, buf_release, frame_done, line_count, busy, timeout_err
  );

  modport slave (
    output seq_en, abort, buf_valid, stall, sobel_ready,
    input  option, computeSobel, buf_release, frame_done, line_count, busy, timeout_err
  );

endinterface

// File: rtl/flex_counter.sv
// rtl/flex_counter.sv - clearable up-counter with terminal-count flag at rollover_val
module flex_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             count_enable,
  input  logic [CNT_W-1:0] rollover_val,
  output logic             rollover_flag
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_enable) begin
      if (count == rollover_val) count <= '0;
      else                       count <= count + 1'b1;
    end
  end

  assign rollover_flag = (count == rollover_val);

endmodule

// File: rtl/sobel_window_sequencer.sv
// rtl/sobel_window_sequencer.sv - per-slice Sobel window request scheduler; SOBEL_SEQ_SKIP_WRAP_EN drops wrap windows
module sobel_window_sequencer
  import sobel_pkg::*;
#(
  parameter int FRAME_LINES = 256,
  parameter int TIMEOUT_CYC = 15,
  parameter int LINE_W      = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1
) (
  input  logic                     clk,
  input  logic                     n_rst,
  sobel_window_sequencer_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  seq_state_t        state;
  seq_state_t        state_nxt;
  logic [OPT_W-1:0]  win_cnt;
  logic [LINE_W-1:0] line_count;
  logic              timeout_err;
  logic              last_line;
  logic              tmo_hit;
  logic              release_fire;

  assign last_line    = (line_count == LINE_W'(FRAME_LINES - 1));
  assign release_fire = (state == RELEASE) && !bus.abort;

  // Counter sits at zero outside WAIT, so it restarts on every WAIT entry;
  // the flag marks the last WAIT cycle in which ready is still accepted.
  flex_counter #(.CNT_W(CNT_W)) u_timeout (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (state != WAIT),
    .count_enable  (state == WAIT),
    .rollover_val  (CNT_W'(TIMEOUT_CYC - 1)),
    .rollover_flag (tmo_hit)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.seq_en && bus.buf_valid) state_nxt = ISSUE;
      ISSUE:   if (!bus.stall) state_nxt = WAIT;
      WAIT: begin
        if (bus.sobel_ready) state_nxt = (win_cnt == LAST_WIN) ? RELEASE : ISSUE;
        else if (tmo_hit)    state_nxt = ERROR;
      end
      RELEASE: state_nxt = IDLE;
      ERROR:   state_nxt = ERROR;
      default: state_nxt = IDLE;
    endcase
    if (bus.abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state       <= IDLE;
      win_cnt     <= '0;
      line_count  <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (bus.abort) begin
        win_cnt     <= '0;
        timeout_err <= 1'b0;
      end else begin
        case (state)
          IDLE: win_cnt <= '0;
          WAIT: begin
            if (bus.sobel_ready) begin
              if (win_cnt != LAST_WIN) win_cnt <= win_cnt + 1'b1;
            end else if (tmo_hit) begin
              timeout_err <= 1'b1;
            end
          end
          RELEASE: begin
            win_cnt    <= '0;
            line_count <= last_line ? '0 : line_count + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.option       = (state == ERROR) ? '0 : win_cnt;
  assign bus.computeSobel = (state == ISSUE) && !bus.stall && !bus.abort;
  assign bus.buf_release  = release_fire;
  assign bus.frame_done   = release_fire && last_line;
  assign bus.line_count   = line_count;
  assign bus.busy         = (state != IDLE);
  assign bus.timeout_err  = timeout_err;

endmodule
